mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 16-bit five-stage pipeline. It consumes the registered EX/MEM controls and data, and performs data-memory reads and writes against an internal word-organised array with byte-lane support. Accesses take a configurable multi-cycle latency, stalling upstream through a small FSM. The stage also holds the MEM/WB pipeline register that feeds write-back.

## Interface
- ADDR_W, 8: word-index width; array depth 2^ADDR_W 16-bit words; byte address is res_in[ADDR_W:0].
- MEM_LAT, 2: total cycles per memory access, ≥1.

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- regWrite, R15Write, memWrite, memRead, sByte, MemtoReg, loadByte  in  1 each  EX/MEM controls
- res_in  in  16  ALU result / byte address
- R15_in  in  16  R15 value
- op1_data_in  in  16  store data
- regDes_in  in  4  destination register
- stall  out  1  hold EX/MEM and earlier stages (combinational)
- regWrite_wb, R15Write_wb, MemtoReg_wb  out  1 each  registered controls
- res_wb, R15_wb, mem_data_wb  out  16  registered ALU result, R15, load data
- regDes_wb  out  4  registered destination

## Operation
- Addressing: word index = res_in[ADDR_W:1]. Byte lanes are big-endian: addr[0]=0 selects [15:8], addr[0]=1 selects [7:0]. Word accesses ignore addr[0]. Upper address bits are ignored.
- Access = memRead | memWrite.
- Store word (sByte=0): the whole word is written with op1_data_in.
- Store byte (sByte=1): op1_data_in[7:0] is written into the selected lane only. The other lane is unchanged.
- Load: loadByte=0 returns the full word. loadByte=1 returns the selected byte, sign-extended to 16 bits.
- Non-read cycles: mem_data_wb captures 0x0000.
- memRead and memWrite together: the write is performed, and mem_data_wb returns the pre-write contents (read-before-write).
- FSM states: IDLE and WAIT, with down-counter cnt (width clog2(MEM_LAT), min 1).
  - IDLE with access and MEM_LAT>1: go to WAIT, cnt←MEM_LAT-2, stall=1.
  - IDLE with access and MEM_LAT=1: complete in the same cycle, stall=0.
  - IDLE with no access: pass-through, stall=0.
  - WAIT with cnt≠0: stall=1, cnt←cnt-1.
  - WAIT with cnt=0: completion cycle, stall=0, go to IDLE.
- Completion cycle: the array write commits on this clock edge, and MEM/WB captures the real controls and data.
- Stall cycles: MEM/WB captures a bubble (regWrite_wb=0, R15Write_wb=0, MemtoReg_wb=0, data 0). No array write occurs.
- While stall=1, upstream holds all inputs stable. Input changes during WAIT are ignored; the access uses the values sampled at completion.
- The memory array is not cleared by reset.

## Timing
- Reset (async, rst=0): state=IDLE, cnt=0, stall=0. All *_wb outputs are 0 / 16'h0000 / 4'h0.
- Reset mid-WAIT aborts the access: no write, no MEM/WB capture. After rst deasserts, the stage starts in IDLE and re-evaluates the held inputs as a new access.
- Non-memory op: 1-cycle latency to MEM/WB, never stalls.
- Memory op: presented at cycle 0.
  - stall is high for cycles 0..MEM_LAT-2.
  - The result appears on *_wb after the edge ending cycle MEM_LAT-1.
  - Back-to-back accesses each take MEM_LAT cycles; there is no idle cycle between them.
- Stores commit on exactly one edge per access. A load immediately following a store to the same word returns the stored data.

## Test plan
- Reset: drive rst=0 mid-run → all outputs zero, stall=0. Release, then present a non-memory op with res_in=0x1234, regWrite=1 → after 1 edge res_wb=0x1234, regWrite_wb=1, no stall.
- Word store/load (MEM_LAT=2):
  - Store 0xBEEF at address 0x0010 → stall=1 for 1 cycle, bubble on WB.
  - Load from 0x0010 → stall=1 for 1 cycle, then mem_data_wb=0xBEEF.
- Byte store/load, using the word at 0x0010 (0xBEEF from the previous case):
  - sByte store 0x80 to 0x0011 → word becomes 0xBE80.
  - loadByte at 0x0011 → 0xFF80.
  - loadByte at 0x0010 → 0xFFBE.
  - Word load → 0xBE80.
- Simultaneous memRead+memWrite, using a word at 0x0020 that holds 0x1111:
  - Write 0x2222 with memRead=1 → mem_data_wb=0x1111.
  - A subsequent load → 0x2222.
- Reset mid-access (MEM_LAT=3): a store of 0x5555 to a word holding 0x0000 is interrupted by asserting rst during WAIT → the word still reads 0x0000 after a clean re-load.
- MEM_LAT=1 build: store then load of 0xA5A5 → stall never asserts, load returns 0xA5A5 one edge after presentation.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the 16-bit five-stage pipeline. Performs data-memory
//   reads and writes against an internal word-organised array with big-endian
//   byte lanes, and holds the MEM/WB pipeline register that feeds write-back.
//   Each access takes MEM_LAT cycles. A two-state FSM (IDLE/WAIT) with a
//   down-counter raises o_stall to hold the upstream stages during the wait.
//
// Parameters
//   ADDR_W  : word-index width; array depth is 2**ADDR_W 16-bit words.
//             The byte address is i_res_in[ADDR_W:0].
//   MEM_LAT : total cycles per memory access (>= 1).
//
// Ports
//   clk                      in   clock, rising edge
//   rst                      in   asynchronous reset, active low
//   i_regWrite, i_R15Write   in   EX/MEM register-write controls
//   i_memWrite, i_memRead    in   EX/MEM memory-access controls
//   i_sByte                  in   store the low byte only
//   i_MemtoReg               in   write-back selects memory data
//   i_loadByte               in   load a sign-extended byte
//   i_res_in     [15:0]      in   ALU result / byte address
//   i_R15_in     [15:0]      in   R15 value
//   i_op1_data_in[15:0]      in   store data
//   i_regDes_in  [3:0]       in   destination register
//   o_stall                  out  hold EX/MEM and earlier stages (combinational)
//   o_regWrite_wb, o_R15Write_wb, o_MemtoReg_wb   out  registered controls
//   o_res_wb, o_R15_wb, o_mem_data_wb [15:0]      out  registered data
//   o_regDes_wb  [3:0]       out  registered destination
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_regWrite,
    input  logic        i_R15Write,
    input  logic        i_memWrite,
    input  logic        i_memRead,
    input  logic        i_sByte,
    input  logic        i_MemtoReg,
    input  logic        i_loadByte,
    input  logic [15:0] i_res_in,
    input  logic [15:0] i_R15_in,
    input  logic [15:0] i_op1_data_in,
    input  logic [3:0]  i_regDes_in,
    output logic        o_stall,
    output logic        o_regWrite_wb,
    output logic        o_R15Write_wb,
    output logic        o_MemtoReg_wb,
    output logic [15:0] o_res_wb,
    output logic [15:0] o_R15_wb,
    output logic [15:0] o_mem_data_wb,
    output logic [3:0]  o_regDes_wb
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam bit MULTI = (MEM_LAT > 1);
    // Wait cycles remaining after the first (stalled) cycle of an access.
    localparam logic [CNT_W-1:0] CNT_LOAD = MULTI ? CNT_W'(MEM_LAT - 2) : '0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_access;
    logic             w_stall;
    logic             w_complete;
    logic             w_we;

    logic [15:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] w_idx;
    logic              w_lane_lo;
    logic [15:0]       w_rd_word;
    logic [7:0]        w_rd_byte;
    logic [15:0]       w_load_data;
    logic [15:0]       w_wr_word;

    assign w_access = i_memRead | i_memWrite;

    // ------------------------------------------------------------------
    // Access-latency FSM
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (MULTI) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                        w_stall     = 1'b1;
                    end else begin
                        w_complete  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stall is forced low while reset is held so upstream is never frozen
    // by an access that reset is about to abort.
    assign o_stall = w_stall & rst;

    // ------------------------------------------------------------------
    // Data array: word index from res_in[ADDR_W:1], lane from res_in[0]
    // (0 = high byte, big-endian).
    // ------------------------------------------------------------------
    assign w_idx     = i_res_in[ADDR_W:1];
    assign w_lane_lo = i_res_in[0];
    assign w_rd_word = r_mem[w_idx];
    assign w_rd_byte = w_lane_lo ? w_rd_word[7:0] : w_rd_word[15:8];

    always_comb begin
        w_load_data = 16'h0000;
        if (i_memRead) begin
            w_load_data = i_loadByte ? {{8{w_rd_byte[7]}}, w_rd_byte} : w_rd_word;
        end
    end

    // Byte stores merge the new low data byte into the selected lane and
    // keep the other lane from the current contents.
    always_comb begin
        w_wr_word = i_op1_data_in;
        if (i_sByte) begin
            w_wr_word = w_lane_lo ? {w_rd_word[15:8], i_op1_data_in[7:0]}
                                  : {i_op1_data_in[7:0], w_rd_word[7:0]};
        end
    end

    // A store commits only on the completion edge, and never under reset.
    assign w_we = w_complete & i_memWrite & rst;

    // NOTE: the array has no reset; clearing it would turn the RAM into
    // thousands of resettable flops and reset never needs to restore it.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB pipeline register: bubble while stalled, real data otherwise.
    // The read uses pre-edge array contents, giving read-before-write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_regWrite_wb <= 1'b0;
            o_R15Write_wb <= 1'b0;
            o_MemtoReg_wb <= 1'b0;
            o_res_wb      <= 16'h0000;
            o_R15_wb      <= 16'h0000;
            o_mem_data_wb <= 16'h0000;
            o_regDes_wb   <= 4'h0;
        end else if (w_stall) begin
            o_regWrite_wb <= 1'b0;
            o_R15Write_wb <= 1'b0;
            o_MemtoReg_wb <= 1'b0;
            o_res_wb      <= 16'h0000;
            o_R15_wb      <= 16'h0000;
            o_mem_data_wb <= 16'h0000;
            o_regDes_wb   <= 4'h0;
        end else begin
            o_regWrite_wb <= i_regWrite;
            o_R15Write_wb <= i_R15Write;
            o_MemtoReg_wb <= i_MemtoReg;
            o_res_wb      <= i_res_in;
            o_R15_wb      <= i_R15_in;
            o_mem_data_wb <= w_load_data;
            o_regDes_wb   <= i_regDes_in;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Three mem_stage instances with MEM_LAT = 1, 2, 3 (instance g has latency
//   g+1), each with its own stimulus. Expected results come from a byte-
//   addressed big-endian memory model per instance.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    typedef struct packed {
        logic        regWrite;
        logic        R15Write;
        logic        memWrite;
        logic        memRead;
        logic        sByte;
        logic        MemtoReg;
        logic        loadByte;
        logic [15:0] res;
        logic [15:0] r15;
        logic [15:0] op1;
        logic [3:0]  rd;
    } op_t;

    typedef struct packed {
        logic        regWrite;
        logic        R15Write;
        logic        MemtoReg;
        logic [15:0] res;
        logic [15:0] r15;
        logic [15:0] mdata;
        logic [3:0]  rd;
    } wb_t;

    logic        clk;
    logic        rst;
    op_t         in_op [3];
    logic [2:0]  stall_a;
    logic [2:0]  rw_a;
    logic [2:0]  r15w_a;
    logic [2:0]  m2r_a;
    logic [15:0] res_a   [3];
    logic [15:0] r15_a   [3];
    logic [15:0] mdata_a [3];
    logic [3:0]  rd_a    [3];

    // Reference model: 512 bytes per instance, word w = {byte 2w, byte 2w+1}.
    logic [7:0] mb [3][512];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage #(.ADDR_W(8), .MEM_LAT(g + 1)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .i_regWrite    (in_op[g].regWrite),
            .i_R15Write    (in_op[g].R15Write),
            .i_memWrite    (in_op[g].memWrite),
            .i_memRead     (in_op[g].memRead),
            .i_sByte       (in_op[g].sByte),
            .i_MemtoReg    (in_op[g].MemtoReg),
            .i_loadByte    (in_op[g].loadByte),
            .i_res_in      (in_op[g].res),
            .i_R15_in      (in_op[g].r15),
            .i_op1_data_in (in_op[g].op1),
            .i_regDes_in   (in_op[g].rd),
            .o_stall       (stall_a[g]),
            .o_regWrite_wb (rw_a[g]),
            .o_R15Write_wb (r15w_a[g]),
            .o_MemtoReg_wb (m2r_a[g]),
            .o_res_wb      (res_a[g]),
            .o_R15_wb      (r15_a[g]),
            .o_mem_data_wb (mdata_a[g]),
            .o_regDes_wb   (rd_a[g])
        );
    end

    function automatic wb_t get_wb(input int g);
        return '{rw_a[g], r15w_a[g], m2r_a[g], res_a[g], r15_a[g], mdata_a[g], rd_a[g]};
    endfunction

    function automatic op_t mk_op(input logic wr, input logic rdm, input logic sb,
                                  input logic lb, input logic [15:0] addr,
                                  input logic [15:0] data);
        op_t o;
        o = '0;
        o.memWrite = wr;
        o.memRead  = rdm;
        o.sByte    = sb;
        o.loadByte = lb;
        o.MemtoReg = rdm;
        o.regWrite = rdm;
        o.res      = addr;
        o.op1      = data;
        o.r15      = 16'h0F0F ^ addr;
        o.rd       = addr[3:0] ^ 4'h5;
        return o;
    endfunction

    // Returns the load data the access should deliver (pre-write contents)
    // and then applies the store to the byte model.
    task automatic model_access(input int g, input op_t op, output logic [15:0] md);
        int a;
        int w;
        logic [7:0] b;
        a  = int'(op.res[8:0]);
        w  = a & ~1;
        b  = mb[g][a];
        md = 16'h0000;
        if (op.memRead)
            md = op.loadByte ? 16'($signed(b)) : {mb[g][w], mb[g][w + 1]};
        if (op.memWrite) begin
            if (op.sByte) begin
                mb[g][a] = op.op1[7:0];
            end else begin
                mb[g][w]     = op.op1[15:8];
                mb[g][w + 1] = op.op1[7:0];
            end
        end
    endtask

    // Presents op to instance g at a falling edge and follows it to completion:
    // stall and a bubble on every wait cycle, full result after the last edge.
    // Returns at a falling edge with the op still driven.
    task automatic run_op(input int g, input op_t op, input string name);
        int   lat;
        wb_t  exp_wb;
        wb_t  act_wb;
        logic [15:0] md;
        lat = (op.memRead | op.memWrite) ? g + 1 : 1;
        model_access(g, op, md);
        exp_wb = '{op.regWrite, op.R15Write, op.MemtoReg, op.res, op.r15, md, op.rd};
        in_op[g] = op;
        for (int c = 0; c < lat; c++) begin
            #1;
            checks++;
            if (stall_a[g] !== (c < lat - 1)) begin
                failures++;
                $display("FAIL %s stall lat%0d cycle%0d: got %b want %b",
                         name, g + 1, c, stall_a[g], (c < lat - 1));
            end
            @(posedge clk);
            #1;
            act_wb = get_wb(g);
            checks++;
            if (c < lat - 1) begin
                if ({act_wb.regWrite, act_wb.R15Write, act_wb.MemtoReg, act_wb.mdata} !== 19'h0) begin
                    failures++;
                    $display("FAIL %s bubble lat%0d cycle%0d: got %h want 0",
                             name, g + 1, c,
                             {act_wb.regWrite, act_wb.R15Write, act_wb.MemtoReg, act_wb.mdata});
                end
            end else if (act_wb !== exp_wb) begin
                failures++;
                $display("FAIL %s wb lat%0d: got %h want %h", name, g + 1, act_wb, exp_wb);
            end
            @(negedge clk);
        end
    endtask

    task automatic set_idle(input int g);
        in_op[g] = '0;
    endtask

    task automatic check_all_zero(input string name);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({stall_a[g], get_wb(g)} !== '0) begin
                failures++;
                $display("FAIL %s inst%0d: got stall=%b wb=%h want all zero",
                         name, g, stall_a[g], get_wb(g));
            end
        end
    endtask

    task automatic test_reset();
        op_t o;
        for (int g = 0; g < 3; g++) set_idle(g);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_initial");
        rst = 1'b1;
        @(negedge clk);
        o = '0;
        o.res = 16'hCAFE; o.regWrite = 1'b1; o.rd = 4'h3;
        run_op(1, o, "pre_reset_alu");
        // Present an access while asserting reset: stall must stay low.
        in_op[1] = mk_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h7777);
        rst = 1'b0;
        #1;
        check_all_zero("reset_midrun");
        @(negedge clk);
        o = '0;
        o.res = 16'h1234; o.regWrite = 1'b1;
        in_op[1] = o;
        rst = 1'b1;
        run_op(1, o, "post_reset_alu");
        set_idle(1);
    endtask

    task automatic test_word();
        run_op(1, mk_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hBEEF), "store_word");
        run_op(1, mk_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000), "load_word");
        set_idle(1);
    endtask

    task automatic test_byte();
        run_op(1, mk_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h1280), "store_byte_lo");
        run_op(1, mk_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000), "loadbyte_lo");
        run_op(1, mk_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000), "loadbyte_hi");
        run_op(1, mk_op(1'b0, 1'b1, 1'b0, 0,    16'h0010, 16'h0000), "load_after_byte");
        // Explicit anchor for the documented value 0xBE80.
        checks++;
        if (mdata_a[1] !== 16'hBE80) begin
            failures++;
            $display("FAIL byte_merge_value: got %h want be80", mdata_a[1]);
        end
        set_idle(1);
    endtask

    task automatic test_read_before_write();
        run_op(1, mk_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h1111), "rbw_init");
        run_op(1, mk_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h2222), "rbw_rw");
        checks++;
        if (mdata_a[1] !== 16'h1111) begin
            failures++;
            $display("FAIL rbw_old_value: got %h want 1111", mdata_a[1]);
        end
        run_op(1, mk_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000), "rbw_reload");
        set_idle(1);
    endtask

    task automatic test_reset_mid_access();
        op_t st;
        run_op(2, mk_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000), "abort_init");
        st = mk_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h5555);
        in_op[2] = st;
        #1;
        checks++;
        if (stall_a[2] !== 1'b1) begin
            failures++;
            $display("FAIL abort_stall: got %b want 1", stall_a[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("abort_reset");
        @(negedge clk);
        in_op[2] = mk_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
        rst = 1'b1;
        run_op(2, in_op[2], "abort_reload");
        set_idle(2);
    endtask

    task automatic test_lat1();
        run_op(0, mk_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'hA5A5), "lat1_store");
        run_op(0, mk_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000), "lat1_load");
        set_idle(0);
    endtask

    // Random back-to-back traffic over 16 pre-initialised words; the upper
    // address bits carry noise that the stage must ignore.
    task automatic test_back_to_back();
        op_t o;
        for (int g = 0; g < 3; g++) begin
            for (int w = 0; w < 16; w++)
                run_op(g, mk_op(1'b1, 1'b0, 1'b0, 1'b0, 16'(w * 2), 16'($urandom)), "rand_init");
            for (int n = 0; n < 60; n++) begin
                o = 16'($urandom) == 0 ? '0 : op_t'({$urandom, $urandom, $urandom});
                o.res = {7'($urandom), 4'b0000, 5'($urandom)};
                run_op(g, o, "rand_op");
            end
            set_idle(g);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int g = 0; g < 3; g++) in_op[g] = '0;
        @(negedge clk);
        test_reset();
        test_word();
        test_byte();
        test_read_before_write();
        test_reset_mid_access();
        test_lat1();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
